// File: rtl/hwint_ctrl.sv
// External interrupt controller feeding CP0 HWint_in: captures level/edge sources,
// masks them and presents a registered vector with a programmable post-ack hold-off.
module hwint_ctrl #(
  parameter int                N_SRC    = 6,
  parameter int                HOLD_W   = 8,
  parameter logic [HOLD_W-1:0] HOLD_RST = 8'd4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_irq,
  input  logic [3:0]       addr,
  input  logic             we,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic             int_ack,
  output logic [5:0]       hwint_out,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [N_SRC-1:0]  src_q, enable, mode, pending;
  logic [N_SRC-1:0]  rise, act, act_low, ack_clr, w1c, pend_nxt;
  logic [5:0]        act6;
  logic [HOLD_W-1:0] hold_len, cnt;
  logic [1:0]        state;
  logic              wr_enable, wr_mode, wr_pend, wr_hold;
  logic              unused_ok;

  assign wr_enable = we && (addr[3:2] == 2'd0);
  assign wr_mode   = we && (addr[3:2] == 2'd1);
  assign wr_pend   = we && (addr[3:2] == 2'd2);
  assign wr_hold   = we && (addr[3:2] == 2'd3);
  assign unused_ok = ^{addr[1:0], wdata[31:HOLD_W]};

  always_comb begin
    rise    = src_irq & ~src_q;
    act     = pending & enable;
    act_low = act & (~act + N_SRC'(1));
    ack_clr = int_ack ? act_low : '0;
    w1c     = wr_pend ? wdata[N_SRC-1:0] : '0;
    // Edge bits: a new rise wins over any clear in the same cycle.
    // Level bits simply follow the captured line.
    pend_nxt = (mode & ((pending & ~(w1c | ack_clr)) | rise)) | (~mode & src_q);
    act6 = '0;
    act6[N_SRC-1:0] = act;
  end

  always_comb begin
    rdata = '0;
    case (addr[3:2])
      2'd0:    rdata[N_SRC-1:0]  = enable;
      2'd1:    rdata[N_SRC-1:0]  = mode;
      2'd2:    rdata[N_SRC-1:0]  = pending;
      default: rdata[HOLD_W-1:0] = hold_len;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q    <= '0;
      enable   <= '0;
      mode     <= '0;
      pending  <= '0;
      hold_len <= HOLD_RST;
    end else begin
      src_q   <= src_irq;
      pending <= pend_nxt;
      if (wr_enable) enable   <= wdata[N_SRC-1:0];
      if (wr_mode)   mode     <= wdata[N_SRC-1:0];
      if (wr_hold)   hold_len <= wdata[HOLD_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hwint_out <= '0;
    end else begin
      hwint_out <= (state == REQ) ? act6 : 6'd0;
      case (state)
        IDLE: if (|act) state <= REQ;
        REQ: begin
          if (int_ack) begin
            state <= HOLD;
            cnt   <= hold_len;
          end else if (act == '0) begin
            state <= IDLE;
          end
        end
        HOLD: begin
          // cnt was loaded at ack; a HOLD write now only affects the next hold-off.
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_hwint_ctrl.sv
// Bench for hwint_ctrl: register table, directed corner sequences, then random
// traffic checked against a cycle-level reference model.
module tb_hwint_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  src_irq = '0;
  logic [3:0]  addr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        int_ack = 1'b0;
  logic [5:0]  hwint_out;
  logic        busy;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  hwint_ctrl dut (
    .clk(clk), .reset(reset), .src_irq(src_irq), .addr(addr), .we(we),
    .wdata(wdata), .rdata(rdata), .int_ack(int_ack), .hwint_out(hwint_out),
    .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 requesting, 2 holding off
  logic [5:0] m_en, m_mode, m_pend, m_srcq, m_out;
  int         m_hold, m_left, m_phase;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_en = 0; m_mode = 0; m_pend = 0; m_srcq = 0; m_out = 0;
      m_hold = 4; m_left = 0; m_phase = 0;
    end else begin
      logic [5:0] act, np;
      int lowest, nphase, nleft;
      act = m_pend & m_en;
      lowest = -1;
      for (int i = 5; i >= 0; i--) if (act[i]) lowest = i;
      for (int i = 0; i < 6; i++) begin
        if (m_mode[i]) begin
          bit set, clr;
          set = src_irq[i] && !m_srcq[i];
          clr = (we && addr[3:2] == 2 && wdata[i]) || (int_ack && i == lowest);
          np[i] = set ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
        end else begin
          np[i] = m_srcq[i];
        end
      end
      nphase = m_phase; nleft = m_left;
      if (m_phase == 0) begin
        if (act != 0) nphase = 1;
      end else if (m_phase == 1) begin
        if (int_ack) begin nphase = 2; nleft = m_hold; end
        else if (act == 0) nphase = 0;
      end else begin
        if (m_left == 0) nphase = 0;
        else nleft = m_left - 1;
      end
      m_out = (m_phase == 1) ? act : 6'd0;
      m_phase = nphase; m_left = nleft;
      m_pend = np;
      m_srcq = src_irq;
      if (we && addr[3:2] == 0) m_en = wdata[5:0];
      if (we && addr[3:2] == 1) m_mode = wdata[5:0];
      if (we && addr[3:2] == 3) m_hold = wdata[7:0];
    end
  end

  function automatic logic [31:0] m_rdata(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return {26'd0, m_en};
      2'd1:    return {26'd0, m_mode};
      2'd2:    return {26'd0, m_pend};
      default: return m_hold;
    endcase
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    addr = a; #1;
    check(name, rdata, exp);
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic wait_hw(input string name, input logic [5:0] exp, input int budget);
    int n = 0;
    while (hwint_out !== exp && n < budget) begin tick(); n++; end
    check(name, hwint_out, exp);
  endtask

  typedef struct {
    logic        do_wr;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 4'h0, 32'hFFFF_FFFF, 32'h0000_003F};
    vecs[1] = '{1'b1, 4'h4, 32'h0000_002A, 32'h0000_002A};
    vecs[2] = '{1'b0, 4'h7, 32'h0,         32'h0000_002A};
    vecs[3] = '{1'b1, 4'hC, 32'h0000_01FF, 32'h0000_00FF};
    vecs[4] = '{1'b1, 4'hD, 32'h0000_0007, 32'h0000_0007};
    vecs[5] = '{1'b1, 4'h1, 32'h0000_0015, 32'h0000_0015};
    vecs[6] = '{1'b1, 4'h8, 32'h0000_003F, 32'h0000_0000};
    vecs[7] = '{1'b1, 4'h4, 32'h0,         32'h0000_0000};

    // reset state
    #12 reset = 1'b1;
    tick();
    check("rst_hwint", hwint_out, 6'd0);
    check("rst_busy", busy, 1'b0);
    read_chk("rst_enable", 4'h0, 32'h0);
    read_chk("rst_mode", 4'h4, 32'h0);
    read_chk("rst_pending", 4'h8, 32'h0);
    read_chk("rst_hold", 4'hC, 32'h4);

    // register table (sources idle, so no interrupts fire)
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_wr) bus_write(vecs[i].a, vecs[i].d);
      read_chk($sformatf("regvec%0d", i), vecs[i].a, vecs[i].exp);
    end
    bus_write(4'h0, 32'h0);
    bus_write(4'hC, 32'h4);

    // T1: edge pulse on source 0
    bus_write(4'h0, 32'h1);
    bus_write(4'h4, 32'h1);
    src_irq = 6'h01; tick();
    src_irq = 6'h00; tick();
    check("t1_not_yet", hwint_out, 6'h00);
    tick();
    check("t1_out", hwint_out, 6'h01);
    tick(); tick();
    check("t1_stays", hwint_out, 6'h01);

    // T2: ack with HOLD=4, busy drops 5 cycles after the ack edge
    ack_pulse();
    tick();
    check("t2_out_zero", hwint_out, 6'h00);
    read_chk("t2_pending", 4'h8, 32'h0);
    tick(); tick(); tick();
    check("t2_busy_held", busy, 1'b1);
    tick();
    check("t2_busy_fall", busy, 1'b0);
    check("t2_out_idle", hwint_out, 6'h00);

    // T3: level source 2
    bus_write(4'h4, 32'h0);
    bus_write(4'h0, 32'h4);
    src_irq = 6'h04;
    wait_hw("t3_level_on", 6'h04, 8);
    ack_pulse(); tick();
    check("t3_holdoff", hwint_out, 6'h00);
    wait_hw("t3_reassert", 6'h04, 16);
    src_irq = 6'h00;
    wait_hw("t3_drop", 6'h00, 8);
    check("t3_idle", busy, 1'b0);

    // T4: rise on the same cycle as W1C keeps the bit set
    bus_write(4'h0, 32'h0);
    bus_write(4'h4, 32'h2);
    src_irq = 6'h02;
    bus_write(4'h8, 32'h2);
    read_chk("t4_set_wins", 4'h8, 32'h2);
    bus_write(4'h8, 32'h2);
    read_chk("t4_w1c", 4'h8, 32'h0);
    src_irq = 6'h00; tick();

    // T5: two edge sources, ack clears lowest only, then disable in REQ
    bus_write(4'h4, 32'h3);
    bus_write(4'h0, 32'h3);
    src_irq = 6'h03; tick();
    src_irq = 6'h00;
    wait_hw("t5_both", 6'h03, 8);
    read_chk("t5_pend3", 4'h8, 32'h3);
    ack_pulse(); tick();
    read_chk("t5_pend2", 4'h8, 32'h2);
    wait_hw("t5_bit1", 6'h02, 16);
    bus_write(4'h0, 32'h0);
    wait_hw("t5_disable", 6'h00, 4);
    check("t5_idle", busy, 1'b0);

    // T6: asynchronous reset in the middle of a hold-off
    bus_write(4'hC, 32'd10);
    bus_write(4'h8, 32'h3F);
    bus_write(4'h4, 32'h1);
    bus_write(4'h0, 32'h1);
    src_irq = 6'h01; tick();
    src_irq = 6'h00;
    wait_hw("t6_req", 6'h01, 8);
    ack_pulse(); tick(); tick();
    check("t6_in_hold", busy, 1'b1);
    #2 reset = 1'b0; #1;
    check("t6_hwint", hwint_out, 6'h00);
    check("t6_busy", busy, 1'b0);
    read_chk("t6_pending", 4'h8, 32'h0);
    read_chk("t6_enable", 4'h0, 32'h0);
    read_chk("t6_hold", 4'hC, 32'h4);
    @(negedge clk) reset = 1'b1;
    tick();

    // random traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      check("rnd_hwint", hwint_out, m_out);
      check("rnd_busy", busy, m_phase != 0);
      check("rnd_rdata", rdata, m_rdata(addr));
      if ($urandom_range(0, 3) == 0) src_irq = src_irq ^ (6'(1) << $urandom_range(0, 5));
      we = ($urandom_range(0, 5) == 0);
      addr = 4'($urandom_range(0, 15));
      wdata = (addr[3:2] == 2'd3) ? $urandom_range(0, 6) : $urandom;
      int_ack = ($urandom_range(0, 3) == 0);
      tick();
    end
    we = 1'b0; int_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
